// File: rtl/instr_encoder_pkg.sv
// Shared instruction-format definitions: opcodes, op kinds and field positions.
// The pipeline control decoder imports the same constants.
package instr_encoder_pkg;

    typedef enum logic [1:0] {
        KIND_SUB = 2'd0,
        KIND_ORI = 2'd1,
        KIND_LW  = 2'd2,
        KIND_SW  = 2'd3
    } op_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } enc_state_e;

    localparam logic [5:0] OP_SUB = 6'b000000;
    localparam logic [5:0] OP_ORI = 6'b000001;
    localparam logic [5:0] OP_LW  = 6'b000010;
    localparam logic [5:0] OP_SW  = 6'b000011;

    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;

    function automatic logic [5:0] opcode_of(input op_kind_e kind);
        logic [5:0] opc;
        case (kind)
            KIND_SUB: opc = OP_SUB;
            KIND_ORI: opc = OP_ORI;
            KIND_LW:  opc = OP_LW;
            default:  opc = OP_SW;
        endcase
        return opc;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: op kind plus register/immediate fields into a 32-bit word.
module instr_pack
    import instr_encoder_pkg::*;
#(
    parameter logic [5:0] SUB_FUNCT = 6'b100010
) (
    input  op_kind_e    kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    output logic [31:0] word
);

    // R-type drops the immediate; I-type drops rd, so stray fields never leak in.
    always_comb begin
        word = '0;
        word[OPC_MSB:OPC_LSB] = opcode_of(kind);
        word[RS_MSB:RS_LSB]   = rs;
        word[RT_MSB:RT_LSB]   = rt;
        if (kind == KIND_SUB) begin
            word[RD_MSB:RD_LSB]       = rd;
            word[FUNCT_MSB:FUNCT_LSB] = SUB_FUNCT;
        end else begin
            word[IMM_MSB:IMM_LSB] = imm;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts instruction descriptors, encodes them and streams the
// words into the instruction memory write port at consecutive addresses.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [5:0]        SUB_FUNCT = 6'b100010
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_kind,
    input  logic [4:0]        op_rs,
    input  logic [4:0]        op_rt,
    input  logic [4:0]        op_rd,
    input  logic [15:0]       op_imm,
    input  logic              op_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] CAPACITY =
        (ADDR_W+1)'(1 << ADDR_W) - (ADDR_W+1)'(BASE_ADDR);

    enc_state_e        state;
    enc_state_e        state_next;
    logic              done_next;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   acc_q;
    logic [ADDR_W:0]   acc_inc;
    logic              err_q;
    logic              done_q;
    logic              pend_valid;
    logic [31:0]       pend_word;
    logic [31:0]       packed_word;
    logic              accept;
    logic              last_slot;

    instr_pack #(
        .SUB_FUNCT(SUB_FUNCT)
    ) u_pack (
        .kind(op_kind_e'(op_kind)),
        .rs  (op_rs),
        .rt  (op_rt),
        .rd  (op_rd),
        .imm (op_imm),
        .word(packed_word)
    );

    assign acc_inc   = acc_q + (ADDR_W+1)'(1);
    assign last_slot = (acc_inc == CAPACITY);

    // A simultaneous abort wins over an accept and also kills the pending write.
    assign op_ready   = (state == ST_RUN) && (acc_q < CAPACITY);
    assign accept     = op_valid && op_ready && !abort;
    assign imem_we    = pend_valid && !abort && (state != ST_IDLE);
    assign imem_addr  = addr_q;
    assign imem_wdata = pend_word;
    assign busy       = (state != ST_IDLE);
    assign done       = done_q;
    assign err        = err_q;
    assign count      = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (accept && (op_last || last_slot)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_next = ST_IDLE;
                done_next  = !abort;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Write register, address/count bookkeeping and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= BASE_ADDR;
            count_q    <= '0;
            acc_q      <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            pend_valid <= 1'b0;
            pend_word  <= '0;
        end else begin
            done_q <= done_next;
            if (state == ST_IDLE && start) begin
                addr_q     <= BASE_ADDR;
                count_q    <= '0;
                acc_q      <= '0;
                err_q      <= 1'b0;
                pend_valid <= 1'b0;
            end else begin
                if (imem_we) begin
                    addr_q  <= addr_q + ADDR_W'(1);
                    count_q <= count_q + (ADDR_W+1)'(1);
                end
                pend_valid <= accept;
                if (accept) begin
                    pend_word <= packed_word;
                    acc_q     <= acc_inc;
                    if (!op_last && last_slot) begin
                        err_q <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized
// sessions compared cycle by cycle against a queue-based behavioural model.
module tb_instr_encoder;

    localparam int         ADDR_W    = 2;
    localparam logic [1:0] BASE_ADDR = 2'd0;
    localparam logic [5:0] SUB_FUNCT = 6'b100010;
    localparam int         CAP       = (1 << ADDR_W) - int'(BASE_ADDR);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, abort, op_valid, op_last;
    logic              op_ready;
    logic [1:0]        op_kind;
    logic [4:0]        op_rs, op_rt, op_rd;
    logic [15:0]       op_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy, done, err;
    logic [ADDR_W:0]   count;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: session flags plus a queue of expected memory writes.
    bit          in_session, taking, m_err, m_done, m_accepted;
    int          accepted, m_count;
    int          wq_addr[$];
    logic [31:0] wq_data[$];
    logic [31:0] obs_words[$];
    int          obs_addr[$];

    instr_encoder #(
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE_ADDR),
        .SUB_FUNCT(SUB_FUNCT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_kind   (op_kind),
        .op_rs     (op_rs),
        .op_rt     (op_rt),
        .op_rd     (op_rd),
        .op_imm    (op_imm),
        .op_last   (op_last),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .count     (count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] encode(input int kind, input int rs, input int rt,
                                           input int rd, input int imm);
        if (kind == 0)
            return 32'((rs << 21) + (rt << 16) + (rd << 11) + int'(SUB_FUNCT));
        return 32'((kind << 26) + (rs << 21) + (rt << 16) + imm);
    endfunction

    task automatic model_reset();
        in_session = 0; taking = 0; m_err = 0; m_done = 0; m_accepted = 0;
        accepted = 0; m_count = 0;
        wq_addr.delete(); wq_data.delete();
    endtask

    task automatic model_step(input bit ready_now);
        m_done = 0;
        m_accepted = 0;
        if (!rst_n) begin
            model_reset();
        end else if (in_session && abort) begin
            wq_addr.delete(); wq_data.delete();
            in_session = 0; taking = 0;
        end else if (in_session) begin
            if (wq_data.size() > 0) begin
                void'(wq_addr.pop_front()); void'(wq_data.pop_front());
                m_count++;
            end
            if (!taking) begin
                in_session = 0;
                m_done = 1;
            end else if (op_valid && ready_now) begin
                wq_addr.push_back(int'(BASE_ADDR) + accepted);
                wq_data.push_back(encode(int'(op_kind), int'(op_rs), int'(op_rt),
                                         int'(op_rd), int'(op_imm)));
                accepted++;
                m_accepted = 1;
                if (op_last) taking = 0;
                else if (accepted == CAP) begin m_err = 1; taking = 0; end
            end
        end else if (start) begin
            in_session = 1; taking = 1; accepted = 0; m_count = 0; m_err = 0;
        end
    endtask

    // One clock: compare outputs mid-cycle, then advance the model at the edge.
    task automatic tick();
        bit exp_ready, exp_we;
        @(negedge clk);
        exp_ready = rst_n && taking && (accepted < CAP);
        exp_we    = rst_n && (wq_data.size() > 0) && !abort;
        checkOutput("op_ready", 64'(op_ready), 64'(exp_ready));
        checkOutput("imem_we",  64'(imem_we),  64'(exp_we));
        checkOutput("busy",     64'(busy),     64'(in_session));
        checkOutput("done",     64'(done),     64'(m_done));
        checkOutput("err",      64'(err),      64'(m_err));
        checkOutput("count",    64'(count),    64'(m_count));
        if (exp_we) begin
            checkOutput("imem_addr",  64'(imem_addr),  64'(wq_addr[0]));
            checkOutput("imem_wdata", 64'(imem_wdata), 64'(wq_data[0]));
        end
        if (imem_we) begin
            obs_words.push_back(imem_wdata);
            obs_addr.push_back(int'(imem_addr));
        end
        @(posedge clk);
        model_step(exp_ready);
        #1;
    endtask

    task automatic idle(input int n);
        start = 0; abort = 0; op_valid = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulseStart();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic applyStimulus(input int kind, input int rs, input int rt, input int rd,
                                 input int imm, input bit last, input int budget,
                                 output bit was_accepted);
        op_kind = 2'(kind); op_rs = 5'(rs); op_rt = 5'(rt); op_rd = 5'(rd);
        op_imm = 16'(imm); op_last = last; op_valid = 1;
        was_accepted = 0;
        for (int i = 0; i < budget && !was_accepted; i++) begin
            tick();
            was_accepted = m_accepted;
        end
        op_valid = 0;
    endtask

    task automatic clearObs();
        obs_words.delete(); obs_addr.delete();
    endtask

    initial begin
        bit acc;
        rst_n = 0; start = 0; abort = 0; op_valid = 0; op_last = 0;
        op_kind = 0; op_rs = 0; op_rt = 0; op_rd = 0; op_imm = 0;
        model_reset();
        #3;
        checkOutput("rst_busy",  64'(busy), 64'd0);
        checkOutput("rst_we",    64'(imem_we), 64'd0);
        checkOutput("rst_count", 64'(count), 64'd0);
        checkOutput("rst_addr",  64'(imem_addr), 64'(BASE_ADDR));
        @(posedge clk); #1;
        rst_n = 1;
        idle(2);

        $display("[TB] single SUB");
        clearObs();
        pulseStart();
        applyStimulus(0, 1, 2, 3, 0, 1, 4, acc);
        idle(3);
        checkOutput("sub_nwrites", 64'(obs_words.size()), 64'd1);
        if (obs_words.size() >= 1) begin
            checkOutput("sub_word", 64'(obs_words[0]), 64'h00221822);
            checkOutput("sub_addr", 64'(obs_addr[0]), 64'd0);
        end
        checkOutput("sub_count", 64'(count), 64'd1);

        $display("[TB] mixed burst");
        clearObs();
        pulseStart();
        applyStimulus(1, 4, 5, 0, 16'h00FF, 0, 4, acc);
        applyStimulus(2, 0, 8, 0, 16'h0010, 0, 4, acc);
        applyStimulus(3, 0, 8, 0, 16'h0004, 1, 4, acc);
        idle(3);
        checkOutput("burst_nwrites", 64'(obs_words.size()), 64'd3);
        if (obs_words.size() >= 3) begin
            checkOutput("burst_w0", 64'(obs_words[0]), 64'h048500FF);
            checkOutput("burst_w1", 64'(obs_words[1]), 64'h08080010);
            checkOutput("burst_w2", 64'(obs_words[2]), 64'h0C080004);
            checkOutput("burst_a2", 64'(obs_addr[2]), 64'd2);
        end
        checkOutput("burst_count", 64'(count), 64'd3);
        checkOutput("burst_err",   64'(err), 64'd0);

        $display("[TB] overflow");
        clearObs();
        pulseStart();
        for (int i = 0; i < 5; i++) applyStimulus(i % 4, i, i + 1, i + 2, i * 3, 0, 4, acc);
        idle(3);
        checkOutput("ovf_nwrites", 64'(obs_words.size()), 64'd4);
        if (obs_addr.size() >= 4) checkOutput("ovf_last_addr", 64'(obs_addr[3]), 64'd3);
        checkOutput("ovf_count", 64'(count), 64'd4);
        checkOutput("ovf_err",   64'(err), 64'd1);

        $display("[TB] gapped valid with unused fields");
        clearObs();
        pulseStart();
        applyStimulus(0, 7, 9, 10, 16'hFFFF, 0, 4, acc);
        idle(3);
        applyStimulus(1, 3, 6, 31, 16'h1234, 1, 4, acc);
        idle(3);
        checkOutput("gap_nwrites", 64'(obs_words.size()), 64'd2);
        if (obs_words.size() >= 2) begin
            checkOutput("gap_sub_word", 64'(obs_words[0]), 64'h00E95022);
            checkOutput("gap_ori_word", 64'(obs_words[1]), 64'h04661234);
            checkOutput("gap_ori_addr", 64'(obs_addr[1]), 64'd1);
        end
        checkOutput("gap_err", 64'(err), 64'd0);

        $display("[TB] abort with accept");
        pulseStart();
        applyStimulus(1, 1, 1, 0, 16'h0001, 0, 4, acc);
        applyStimulus(1, 2, 2, 0, 16'h0002, 0, 4, acc);
        op_valid = 1; op_kind = 2; op_rs = 3; op_rt = 3; op_imm = 16'h0003; op_last = 0;
        abort = 1;
        tick();
        abort = 0; op_valid = 0;
        idle(3);
        checkOutput("abort_busy", 64'(busy), 64'd0);
        clearObs();
        pulseStart();
        applyStimulus(0, 4, 5, 6, 0, 1, 4, acc);
        idle(3);
        if (obs_addr.size() >= 1) checkOutput("restart_addr", 64'(obs_addr[0]), 64'(BASE_ADDR));
        checkOutput("restart_count", 64'(count), 64'd1);

        $display("[TB] async reset mid-burst and start while busy");
        pulseStart();
        applyStimulus(3, 1, 2, 0, 16'h0040, 0, 4, acc);
        op_valid = 1; op_kind = 1; op_last = 0;
        tick();
        rst_n = 0;
        #2;
        checkOutput("arst_busy",     64'(busy), 64'd0);
        checkOutput("arst_we",       64'(imem_we), 64'd0);
        checkOutput("arst_ready",    64'(op_ready), 64'd0);
        checkOutput("arst_count",    64'(count), 64'd0);
        checkOutput("arst_wdata",    64'(imem_wdata), 64'd0);
        model_reset();
        op_valid = 0;
        tick();
        rst_n = 1;
        clearObs();
        pulseStart();
        applyStimulus(2, 5, 6, 0, 16'h0008, 0, 4, acc);
        pulseStart();
        applyStimulus(3, 5, 6, 0, 16'h000C, 1, 4, acc);
        idle(3);
        checkOutput("busystart_nwrites", 64'(obs_addr.size()), 64'd2);
        if (obs_addr.size() >= 2) checkOutput("busystart_addr1", 64'(obs_addr[1]), 64'd1);
        checkOutput("busystart_count", 64'(count), 64'd2);

        $display("[TB] randomized sessions");
        for (int s = 0; s < 40; s++) begin
            int n, abort_at;
            n = $urandom_range(1, 6);
            abort_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
            pulseStart();
            for (int i = 0; i < n && taking; i++) begin
                if (i == abort_at) begin
                    op_valid = $urandom_range(0, 1) != 0;
                    op_kind = 2'($urandom_range(0, 3));
                    abort = 1;
                    tick();
                    abort = 0; op_valid = 0;
                    break;
                end
                start = ($urandom_range(0, 7) == 0);
                applyStimulus($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31),
                              $urandom_range(0, 31), $urandom_range(0, 65535), i == n - 1, 4, acc);
                start = 0;
                idle($urandom_range(0, 2));
            end
            idle(3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encodes instruction descriptors (op kind, register fields, immediate) into 32-bit instruction words.
- Covers the four opcodes the pipeline control decoder understands: SUB, ORI, LW, SW.
- Streams the words into the instruction memory write port at consecutive addresses.
- Acts as the program loader / test-program generator feeding the IF stage, i.e. the producing end of the opcode/field format the decode stage consumes.

Parameters:
- ADDR_W, 8, instruction memory word-address width; capacity is 2^ADDR_W words.
- BASE_ADDR, 0, first word address written after start.
- SUB_FUNCT, 6'b100010, funct field emitted for SUB.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle pulse; begins a load session.
- abort  in  1  synchronous; terminates a session, drops any pending write.
- op_valid  in  1  descriptor valid.
- op_ready  out  1  encoder can accept a descriptor.
- op_kind  in  2  0=SUB, 1=ORI, 2=LW, 3=SW.
- op_rs  in  5  source register.
- op_rt  in  5  rt (second source for SUB/SW, destination for ORI/LW).
- op_rd  in  5  destination for SUB.
- op_imm  in  16  immediate/offset for ORI/LW/SW.
- op_last  in  1  marks the final descriptor of the session.
- imem_we  out  1  instruction memory write enable.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  32  encoded instruction.
- busy  out  1  session active.
- done  out  1  single-cycle pulse at session end.
- err  out  1  sticky overflow flag; cleared by start.
- count  out  ADDR_W+1  words written this session.

Behaviour:
- Reset: all outputs 0; state IDLE; write address = BASE_ADDR; pending-write register empty.
- Encoding is fixed:
  - SUB = {6'b000000, rs, rt, rd, 5'b0, SUB_FUNCT}
  - ORI = {6'b000001, rs, rt, imm}
  - LW = {6'b000010, rs, rt, imm}
  - SW = {6'b000011, rs, rt, imm}
  - Unused fields are ignored: op_rd for I-type, op_imm for SUB.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - op_ready=0, busy=0.
  - start → addr=BASE_ADDR, count=0, err=0, go to RUN.
- RUN:
  - busy=1, op_ready=1 unless capacity is exhausted.
  - Accept occurs when op_valid && op_ready. The encoded word is registered.
  - The following cycle: imem_we=1, imem_addr=current addr, imem_wdata=word. Latency is 1 cycle from accept to write.
  - addr and count increment with each write.
  - Throughput is 1 descriptor per cycle; back-to-back accepts produce back-to-back writes.
  - Accepting op_last → go to DRAIN, op_ready=0.
- Capacity:
  - op_ready drops once the accepted-word total reaches 2^ADDR_W - (BASE_ADDR) words.
  - If that final accepted word does not carry op_last → err=1, go to DRAIN.
- DRAIN:
  - Completes the pending write.
  - done=1 on the cycle after the last imem_we, then go to IDLE.
  - count holds its final value until the next start.
- Address wraps never occur; capacity logic prevents them.
- start while busy: ignored.
- op_valid in IDLE or DRAIN: ignored (not accepted).
- abort in RUN/DRAIN:
  - Go to IDLE next cycle; the pending write is suppressed (imem_we=0).
  - No done pulse; err unchanged.
  - abort takes priority over a simultaneous accept.
- Asynchronous rst_n mid-session: immediate return to reset values; a partially loaded program is not rolled back.
- imem_we is never asserted outside RUN/DRAIN.

Decomposition:
- Shared pipeline package holds the opcode constants (OP_SUB=6'b000000, OP_ORI=6'b000001, OP_LW=6'b000010, OP_SW=6'b000011), the op_kind enum, and the field bit positions [31:26]/[25:21]/[20:16]/[15:11]/[15:0]. The control decoder uses the same constants.
- One combinational sub-module, instr_pack: op_kind + fields → 32-bit word. The top level holds the FSM, counters and the write register.

Test Plan:
- Single SUB: start; op_kind=0, rs=1, rt=2, rd=3, last=1 → one cycle later imem_we=1, addr=0x00, wdata=0x00221822; done pulses next cycle; count=1.
- Mixed burst, back-to-back, no stalls: ORI rs=4 rt=5 imm=0x00FF; LW rs=0 rt=8 imm=0x0010; SW rs=0 rt=8 imm=0x0004 (last) → addr 0,1,2 on consecutive cycles, wdata 0x048500FF, 0x08080010, 0x0C080004; count=3, err=0.
- Overflow with ADDR_W=2: 5 descriptors, none last → 4 writes (addr 0..3); op_ready low after 4th accept; err=1; done pulse; 5th never accepted.
- Gapped op_valid plus unused fields: SUB with imm=0xFFFF and ORI with rd=31, with idle cycles between them → no write in gap cycles; unused fields do not appear in wdata; addr increments only on writes.
- abort in the same cycle as an accept mid-burst → that descriptor is not written, no done, state IDLE; a subsequent start restarts at BASE_ADDR with count=0.
- rst_n asserted low mid-burst → all outputs 0 immediately; start after release behaves as a fresh session; start pulsed while busy is ignored (addr is not reset).
